// File: rtl/bus1_arbiter.sv
// Round-robin owner arbiter for the shared CPU<->cache bus1. Holds one grant for a whole
// A1/D1/C1 transaction by passively tracking the C1 phases, then hands the bus back.
module bus1_arbiter #(
    parameter int N_REQ          = 2,
    parameter int C1_BUS_SIZE    = 3,
    parameter int CMD_WAIT       = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [N_REQ-1:0]         REQ,
    output logic [N_REQ-1:0]         GNT,
    input  logic [C1_BUS_SIZE-1:0]   C1_WIRE,
    output logic                     BUSY,
    output logic [$clog2(N_REQ)-1:0] OWNER,
    output logic                     ERR
);
    localparam int OW = $clog2(N_REQ);

    typedef logic [C1_BUS_SIZE-1:0] c1_t;
    localparam c1_t C1_NOP     = c1_t'(0);
    localparam c1_t C1_READ32  = c1_t'(3);
    localparam c1_t C1_WRITE32 = c1_t'(7);
    localparam c1_t C1_RESP    = c1_t'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_CMD,
        S_WAIT_NOP,
        S_WAIT_RESP,
        S_RESP,
        S_TURN
    } state_t;

    state_t        state, state_n;
    logic [OW-1:0] owner, owner_n;
    logic [OW-1:0] rr_ptr, rr_n;
    c1_t           cmd, cmd_n;
    logic          beat, beat_n;
    logic [7:0]    wait_cnt, wait_n;
    logic [7:0]    tmo_cnt, tmo_n;
    logic [7:0]    tmo_inc;
    logic          err, err_n;
    logic [OW-1:0] pick;
    logic          found;
    logic          in_txn;

    // First asserted requester at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && REQ[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                pick  = OW'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign tmo_inc = (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;

    always_comb begin
        state_n = state;
        owner_n = owner;
        rr_n    = rr_ptr;
        cmd_n   = cmd;
        beat_n  = beat;
        wait_n  = wait_cnt;
        tmo_n   = tmo_cnt;
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    owner_n = pick;
                    wait_n  = '0;
                    state_n = S_GRANT;
                end
            end
            S_GRANT: begin
                if (C1_WIRE != C1_NOP) begin
                    cmd_n   = C1_WIRE;
                    beat_n  = 1'b0;
                    tmo_n   = '0;
                    state_n = S_CMD;
                end else if (!REQ[owner] || wait_cnt == 8'(CMD_WAIT - 1)) begin
                    err_n   = 1'b1;
                    state_n = S_TURN;
                end else begin
                    wait_n = wait_cnt + 8'd1;
                end
            end
            S_CMD: begin
                // 32-bit transfers carry a second A1/D1 beat.
                if ((cmd == C1_READ32 || cmd == C1_WRITE32) && !beat) begin
                    beat_n = 1'b1;
                end else begin
                    beat_n  = 1'b0;
                    state_n = S_WAIT_NOP;
                end
            end
            S_WAIT_NOP, S_WAIT_RESP: begin
                tmo_n = tmo_inc;
                if (state == S_WAIT_RESP && C1_WIRE == C1_RESP) begin
                    beat_n  = 1'b0;
                    state_n = S_RESP;
                end else if (tmo_inc >= 8'(TIMEOUT_CYCLES)) begin
                    err_n   = 1'b1;
                    state_n = S_TURN;
                end else if (state == S_WAIT_NOP && C1_WIRE == C1_NOP) begin
                    state_n = S_WAIT_RESP;
                end
            end
            S_RESP: begin
                if (cmd == C1_READ32 && !beat) begin
                    beat_n = 1'b1;
                end else begin
                    beat_n  = 1'b0;
                    state_n = S_TURN;
                end
            end
            S_TURN: begin
                rr_n    = (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            cmd      <= C1_NOP;
            beat     <= 1'b0;
            wait_cnt <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_n;
            cmd      <= cmd_n;
            beat     <= beat_n;
            wait_cnt <= wait_n;
            tmo_cnt  <= tmo_n;
            err      <= err_n;
        end
    end

    // Outputs decode straight from registered state so async reset clears them at once.
    assign in_txn = (state != S_IDLE) && (state != S_TURN);

    for (genvar g = 0; g < N_REQ; g++) begin : g_gnt
        assign GNT[g] = in_txn && (owner == OW'(g));
    end

    assign BUSY  = (state != S_IDLE);
    assign OWNER = owner;
    assign ERR   = err;

endmodule

// File: tb/tb_bus1_arbiter.sv
// Randomized transaction bench for bus1_arbiter: requester/cache behaviour is scripted per
// transaction and the expected grant window is computed from the phase lengths.
module tb_bus1_arbiter;
    localparam int N    = 3;
    localparam int CW   = 4;
    localparam int T    = 8;
    localparam int C1W  = 3;
    localparam int K_NRM = 0, K_RTO = 1, K_NC = 2, K_AB = 3, K_RST = 4;

    logic                 CLK = 1'b0;
    logic                 RESET;
    logic [N-1:0]         REQ;
    logic [N-1:0]         GNT;
    logic [C1W-1:0]       C1;
    logic                 BUSY;
    logic [$clog2(N)-1:0] OWNER;
    logic                 ERR;

    int total, bad;
    int rr, last_own;
    bit in_turn;
    int dir_kind [7] = '{K_NRM, K_NRM, K_NRM, K_RTO, K_NC, K_AB, K_RST};
    int dir_cmd  [3] = '{1, 3, 7};

    bus1_arbiter #(
        .N_REQ(N), .C1_BUS_SIZE(C1W), .CMD_WAIT(CW), .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .GNT(GNT), .C1_WIRE(C1),
        .BUSY(BUSY), .OWNER(OWNER), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pk(input logic [N-1:0] g, input logic b, input logic e);
        return 32'({g, b, e});
    endfunction

    function automatic logic [31:0] obs();
        return pk(GNT, BUSY, ERR);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] pat, input int ptr);
        for (int i = 0; i < N; i++)
            if (pat[(ptr + i) % N]) return (ptr + i) % N;
        return 0;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // REQ already holds pat and the DUT is in IDLE about to sample it.
    task automatic txn(input int kind, input int cmd_arg);
        int w, cmd, cc, rc, d, h, n, last;
        logic [N-1:0] oh;
        w  = rr_pick(REQ, rr);
        oh = N'(1 << w);
        C1 = '0;
        step();
        chk("gnt_rise", obs(), pk(oh, 1'b1, 1'b0));
        chk("owner", 32'(OWNER), 32'(w));

        if (kind == K_NC) begin
            for (int k = 1; k <= CW; k++) begin
                REQ = (N'($urandom) & ~oh) | oh;
                step();
                chk(k < CW ? "nc_hold" : "nc_err", obs(),
                    k < CW ? pk(oh, 1'b1, 1'b0) : pk('0, 1'b1, 1'b1));
            end
        end else if (kind == K_AB) begin
            d = $urandom_range(0, CW - 1);
            for (int k = 1; k <= d; k++) begin
                REQ = (N'($urandom) & ~oh) | oh;
                step();
                chk("ab_hold", obs(), pk(oh, 1'b1, 1'b0));
            end
            REQ = N'($urandom) & ~oh;
            step();
            chk("ab_err", obs(), pk('0, 1'b1, 1'b1));
        end else begin
            d = (kind == K_RST) ? 0 : $urandom_range(0, CW - 1);
            for (int k = 1; k <= d; k++) begin
                REQ = (N'($urandom) & ~oh) | oh;
                step();
                chk("pre_cmd", obs(), pk(oh, 1'b1, 1'b0));
            end
            cmd = (cmd_arg != 0) ? cmd_arg : $urandom_range(1, 7);
            cc  = (cmd == 3 || cmd == 7) ? 2 : 1;
            rc  = (cmd == 3) ? 2 : 1;
            h   = cc + ((cmd_arg == 7) ? 2 : $urandom_range(0, 2));
            n   = $urandom_range(1, 4);
            C1  = C1W'(cmd);
            step();
            chk("cmd_edge", obs(), pk(oh, 1'b1, 1'b0));
            if (kind == K_RST) begin
                for (int k = 1; k <= h + 2; k++) begin
                    C1 = (k <= h) ? C1W'(cmd) : '0;
                    step();
                    chk("pre_rst", obs(), pk(oh, 1'b1, 1'b0));
                end
                #2 RESET = 1'b1;
                #1;
                chk("rst_async", obs(), pk('0, 1'b0, 1'b0));
                chk("rst_own", 32'(OWNER), 32'd0);
                step();
                chk("rst_hold", obs(), pk('0, 1'b0, 1'b0));
                REQ = '0;
                C1  = '0;
                RESET = 1'b0;
                rr = 0;
                last_own = 0;
                in_turn = 1'b0;
                return;
            end
            last = (kind == K_RTO) ? cc + T : h + n + 1 + rc;
            for (int k = 1; k <= last; k++) begin
                if (k <= h)
                    C1 = C1W'(cmd);
                else if (kind == K_NRM && k > h + n && k <= h + n + rc)
                    C1 = 3'd7;
                else
                    C1 = '0;
                REQ = N'($urandom);
                step();
                if (k < last)
                    chk("txn_hold", obs(), pk(oh, 1'b1, 1'b0));
                else
                    chk(kind == K_RTO ? "tmo_err" : "turn", obs(),
                        pk('0, 1'b1, kind == K_RTO));
            end
        end
        C1 = '0;
        rr = (w + 1) % N;
        last_own = w;
        in_turn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1);
    end

    initial begin
        total = 0;
        bad = 0;
        rr = 0;
        last_own = 0;
        in_turn = 1'b0;
        RESET = 1'b1;
        REQ = '0;
        C1 = '0;
        #12;
        chk("reset_out", obs(), pk('0, 1'b0, 1'b0));
        chk("reset_own", 32'(OWNER), 32'd0);
        step();
        RESET = 1'b0;
        repeat (2) begin
            step();
            chk("idle", obs(), pk('0, 1'b0, 1'b0));
        end
        for (int t = 0; t < 80; t++) begin
            int kind, cmd_arg, gap, r;
            logic [N-1:0] pat;
            r = $urandom_range(0, 9);
            kind = (t < 7) ? dir_kind[t] : ((r <= 5) ? K_NRM : r - 5);
            cmd_arg = (t < 3) ? dir_cmd[t] : 0;
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            pat = N'($urandom_range(1, (1 << N) - 1));
            if (in_turn) begin
                REQ = (gap != 0) ? '0 : pat;
                step();
                chk("turn_end", obs(), pk('0, 1'b0, 1'b0));
                chk("last_own", 32'(OWNER), 32'(last_own));
                in_turn = 1'b0;
            end
            if (gap != 0) begin
                REQ = '0;
                repeat (gap) begin
                    step();
                    chk("gap_idle", obs(), pk('0, 1'b0, 1'b0));
                end
            end
            REQ = pat;
            txn(kind, cmd_arg);
        end
        if (in_turn) begin
            REQ = '0;
            step();
            chk("final_idle", obs(), pk('0, 1'b0, 1'b0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
